// File: rtl/evo_const_pkg.sv
// -----------------------------------------------------------------------------
// evo_const_pkg
// Shared constants and types for the evo GPIO port controller:
//   - CSR word offsets inside the 16-word block (EVO_GPIO_*_OFS)
//   - edge_mode_e : pin-change edge selection held in CTRL[1:0]
//   - ctrl_t      : packed layout of the CTRL register
//   - alias_op_e  : the write/clear/set/toggle alias encoded by offset[1:0]
//   - alias_update: applies one alias write to a 32-bit register value
// -----------------------------------------------------------------------------
package evo_const_pkg;

  localparam logic [3:0] EVO_GPIO_DIR_OFS    = 4'h0;
  localparam logic [3:0] EVO_GPIO_DIRCLR_OFS = 4'h1;
  localparam logic [3:0] EVO_GPIO_DIRSET_OFS = 4'h2;
  localparam logic [3:0] EVO_GPIO_DIRTGL_OFS = 4'h3;
  localparam logic [3:0] EVO_GPIO_OUT_OFS    = 4'h4;
  localparam logic [3:0] EVO_GPIO_OUTCLR_OFS = 4'h5;
  localparam logic [3:0] EVO_GPIO_OUTSET_OFS = 4'h6;
  localparam logic [3:0] EVO_GPIO_OUTTGL_OFS = 4'h7;
  localparam logic [3:0] EVO_GPIO_IN_OFS     = 4'h8;
  localparam logic [3:0] EVO_GPIO_CTRL_OFS   = 4'h9;
  localparam logic [3:0] EVO_GPIO_PCMSK_OFS  = 4'hA;
  localparam logic [3:0] EVO_GPIO_PCIFR_OFS  = 4'hB;

  typedef enum logic [1:0] {
    EDGE_ANY  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_OFF  = 2'd3
  } edge_mode_e;

  typedef struct packed {
    logic       irqen;  // bit 2
    edge_mode_e mode;   // bits [1:0]
  } ctrl_t;

  // The low two offset bits of the DIR and OUT groups select the alias.
  typedef enum logic [1:0] {
    ALIAS_WR  = 2'd0,
    ALIAS_CLR = 2'd1,
    ALIAS_SET = 2'd2,
    ALIAS_TGL = 2'd3
  } alias_op_e;

  function automatic logic [31:0] alias_update(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input alias_op_e   op);
    logic [31:0] res;
    case (op)
      ALIAS_WR:  res = wd;
      ALIAS_CLR: res = cur & ~wd;
      ALIAS_SET: res = cur | wd;
      default:   res = cur ^ wd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/evo_gpio_sync.sv
// -----------------------------------------------------------------------------
// evo_gpio_sync
// Per-bit input synchroniser of STAGES flops followed by one history flop.
// The pair (sync_o, hist_o) feeds the edge detector in the port controller.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   pad_i   : raw asynchronous pad levels
//   sync_o  : synchronised level (last chain stage)
//   hist_o  : sync_o delayed by one cycle
// -----------------------------------------------------------------------------
module evo_gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] hist_o
);

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the chain is reset as well so port_in starts at 0 and the edge
      // detector sees no phantom transition when reset is released.
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
      hist_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous
      // stage's old value; blocking ones would collapse the chain to one flop.
      chain_q[0] <= pad_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      hist_q <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign hist_o = hist_q;

endmodule

// File: rtl/evo_gpio_port.sv
// -----------------------------------------------------------------------------
// evo_gpio_port
// One GPIO port of up to 32 pads on the 12-bit/32-bit CSR bus.
//   clk, reset_n        : clock, asynchronous active-low reset
//   csr_address         : word address; block selected on [11:4] == BASE_ADDR[11:4]
//   csr_write/csr_read  : strobes; csr_writedata is the write payload
//   csr_readdata        : registered read data, 0 whenever csr_readdatavalid is 0
//   csr_readdatavalid   : one-cycle pulse, the cycle after a selected read strobe
//   pad_in              : raw pad inputs
//   port_out / port_oe  : output values / enables (OUT / DIR) to the pin mux
//   port_in             : synchronised pad levels
//   irq                 : level interrupt, CTRL.IRQEN & |PCIFR
// Bits outside the effective mask (PADMASK limited to DWIDTH) are never stored.
// -----------------------------------------------------------------------------
module evo_gpio_port
  import evo_const_pkg::*;
#(
  parameter int          DWIDTH        = 32,
  parameter logic [31:0] PADMASK       = 32'hFFFF_FFFF,
  parameter logic [11:0] BASE_ADDR     = 12'h000,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [31:0] DIR_RST_VAL   = 32'h0,
  parameter logic [31:0] OUT_RST_VAL   = 32'h0,
  parameter logic [31:0] CTRL_RST_VAL  = 32'h0,
  parameter logic [31:0] PCMSK_RST_VAL = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [11:0]       csr_address,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              csr_readdatavalid,
  input  logic [DWIDTH-1:0] pad_in,
  output logic [DWIDTH-1:0] port_out,
  output logic [DWIDTH-1:0] port_oe,
  output logic [DWIDTH-1:0] port_in,
  output logic              irq
);

  // For DWIDTH == 32 the shift wraps to 0 and the subtraction to all ones,
  // which is exactly the full-width mask.
  localparam logic [31:0]       EM32 = PADMASK & ((32'd1 << DWIDTH) - 32'd1);
  localparam logic [DWIDTH-1:0] EM   = EM32[DWIDTH-1:0];

  if (DWIDTH < 1 || DWIDTH > 32) begin : g_bad_width
    $error("evo_gpio_port: DWIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("evo_gpio_port: SYNC_STAGES must be 2..3");
  end
  if (BASE_ADDR[3:0] != 4'h0) begin : g_bad_base
    $error("evo_gpio_port: BASE_ADDR must be 16-word aligned");
  end

  // Storage is kept 32 bits wide so the read mux and alias helper work on
  // whole words; bits outside EM32 stay constant 0 and are trimmed away.
  logic [31:0] dir_q,   dir_d;
  logic [31:0] out_q,   out_d;
  logic [31:0] pcmsk_q, pcmsk_d;
  logic [31:0] pcifr_q, pcifr_d;
  ctrl_t       ctrl_q,  ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic        sel, wr_en, rd_en;
  logic [3:0]  ofs;
  alias_op_e   alias_op;
  logic [31:0] w1c;
  logic [31:0] rmux;

  logic [DWIDTH-1:0] sync_bits, hist_bits;
  logic [DWIDTH-1:0] rise, fall, evt;
  logic [31:0]       set_bits;

  // ---------------------------------------------------------------------------
  // Input path: unimplemented pads are masked before the synchroniser so
  // port_in and IN read 0 there.
  // ---------------------------------------------------------------------------
  evo_gpio_sync #(
    .WIDTH  (DWIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (reset_n),
    .pad_i  (pad_in & EM),
    .sync_o (sync_bits),
    .hist_o (hist_bits)
  );

  assign rise = sync_bits & ~hist_bits;
  assign fall = ~sync_bits & hist_bits;

  always_comb begin
    case (ctrl_q.mode)
      EDGE_ANY:  evt = rise | fall;
      EDGE_RISE: evt = rise;
      EDGE_FALL: evt = fall;
      default:   evt = '0;
    endcase
  end

  assign set_bits = 32'(evt) & pcmsk_q & EM32;

  // ---------------------------------------------------------------------------
  // CSR decode and register next-state
  // ---------------------------------------------------------------------------
  assign sel      = (csr_address[11:4] == BASE_ADDR[11:4]);
  assign ofs      = csr_address[3:0];
  assign wr_en    = sel & csr_write;
  assign rd_en    = sel & csr_read;
  assign alias_op = alias_op_e'(ofs[1:0]);

  always_comb begin
    // NOTE: every next-state value starts from its hold value, so no branch
    // can leave it unassigned and infer a latch.
    dir_d   = dir_q;
    out_d   = out_q;
    ctrl_d  = ctrl_q;
    pcmsk_d = pcmsk_q;
    w1c     = '0;
    if (wr_en) begin
      case (ofs)
        EVO_GPIO_DIR_OFS, EVO_GPIO_DIRCLR_OFS,
        EVO_GPIO_DIRSET_OFS, EVO_GPIO_DIRTGL_OFS:
          dir_d = alias_update(dir_q, csr_writedata, alias_op) & EM32;
        EVO_GPIO_OUT_OFS, EVO_GPIO_OUTCLR_OFS,
        EVO_GPIO_OUTSET_OFS, EVO_GPIO_OUTTGL_OFS:
          out_d = alias_update(out_q, csr_writedata, alias_op) & EM32;
        EVO_GPIO_CTRL_OFS:  ctrl_d  = ctrl_t'(csr_writedata[2:0]);
        EVO_GPIO_PCMSK_OFS: pcmsk_d = csr_writedata & EM32;
        EVO_GPIO_PCIFR_OFS: w1c     = csr_writedata;
        default: ;  // IN is read-only, C..F reserved
      endcase
    end
    // A new event wins over a same-cycle write-1-to-clear of that flag.
    pcifr_d = (pcifr_q & ~w1c) | set_bits;
  end

  // Read mux works on pre-write register values, so a read colliding with a
  // write returns the old contents.
  always_comb begin
    case (ofs)
      EVO_GPIO_DIR_OFS, EVO_GPIO_DIRCLR_OFS,
      EVO_GPIO_DIRSET_OFS, EVO_GPIO_DIRTGL_OFS: rmux = dir_q;
      EVO_GPIO_OUT_OFS, EVO_GPIO_OUTCLR_OFS,
      EVO_GPIO_OUTSET_OFS, EVO_GPIO_OUTTGL_OFS: rmux = out_q;
      EVO_GPIO_IN_OFS:    rmux = 32'(sync_bits);
      EVO_GPIO_CTRL_OFS:  rmux = {29'b0, ctrl_q};
      EVO_GPIO_PCMSK_OFS: rmux = pcmsk_q;
      EVO_GPIO_PCIFR_OFS: rmux = pcifr_q;
      default:            rmux = '0;
    endcase
    // Zero when idle so several slaves can be OR-combined on the fabric.
    rdata_d  = rd_en ? rmux : '0;
    rvalid_d = rd_en;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q    <= DIR_RST_VAL & EM32;
      out_q    <= OUT_RST_VAL & EM32;
      ctrl_q   <= ctrl_t'(CTRL_RST_VAL[2:0] & EM32[2:0]);
      pcmsk_q  <= PCMSK_RST_VAL & EM32;
      pcifr_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      out_q    <= out_d;
      ctrl_q   <= ctrl_d;
      pcmsk_q  <= pcmsk_d;
      pcifr_q  <= pcifr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign csr_readdata      = rdata_q;
  assign csr_readdatavalid = rvalid_q;
  assign port_out          = out_q[DWIDTH-1:0];
  assign port_oe           = dir_q[DWIDTH-1:0];
  assign port_in           = sync_bits;
  assign irq               = ctrl_q.irqen & (|pcifr_q);

endmodule

// File: tb/tb_evo_gpio_port.sv
// -----------------------------------------------------------------------------
// tb_evo_gpio_port
// Self-checking bench for evo_gpio_port (DWIDTH=26, PADMASK=32'h03803f73,
// DIR_RST_VAL=32'h0F). A directed vector table covers the register aliases,
// pin-change flags and read protocol; random traffic is compared every cycle
// against a reference model that keeps the pad samples in a delay line.
// -----------------------------------------------------------------------------
module tb_evo_gpio_port;

  localparam int          DW   = 26;
  localparam logic [31:0] PM   = 32'h0380_3F73;
  localparam logic [11:0] BASE = 12'h040;
  localparam int          SS   = 2;
  localparam logic [31:0] EM   = PM & 32'h03FF_FFFF;
  localparam logic [31:0] DIR_RV = 32'h0000_000F;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [11:0]   csr_address;
  logic          csr_write, csr_read;
  logic [31:0]   csr_writedata;
  logic [31:0]   csr_readdata;
  logic          csr_readdatavalid;
  logic [DW-1:0] pad_in, port_out, port_oe, port_in;
  logic          irq;

  always #5 clk = ~clk;

  evo_gpio_port #(
    .DWIDTH        (DW),
    .PADMASK       (PM),
    .BASE_ADDR     (BASE),
    .SYNC_STAGES   (SS),
    .DIR_RST_VAL   (DIR_RV),
    .OUT_RST_VAL   (32'h0),
    .CTRL_RST_VAL  (32'h0),
    .PCMSK_RST_VAL (32'h0)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .csr_address       (csr_address),
    .csr_write         (csr_write),
    .csr_read          (csr_read),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .pad_in            (pad_in),
    .port_out          (port_out),
    .port_oe           (port_oe),
    .port_in           (port_in),
    .irq               (irq)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_dir, m_out, m_pcmsk, m_pcifr;
  logic [2:0]  m_ctrl;
  logic        m_rv;
  logic [31:0] m_rd;
  logic [31:0] samp[$];  // samp[k] = masked pad level sampled k edges ago

  task automatic model_reset();
    m_dir = DIR_RV & EM; m_out = 0; m_ctrl = 0; m_pcmsk = 0; m_pcifr = 0;
    m_rv = 0; m_rd = 0;
    samp.delete();
    repeat (SS + 1) samp.push_back(32'h0);
  endtask

  function automatic logic [31:0] reg_value(input logic [3:0] o);
    if (o < 4)        return m_dir;
    else if (o < 8)   return m_out;
    else if (o == 8)  return samp[SS-1];
    else if (o == 9)  return {29'b0, m_ctrl};
    else if (o == 10) return m_pcmsk;
    else if (o == 11) return m_pcifr;
    return 32'h0;
  endfunction

  task automatic model_step(input logic [11:0] a, input logic wr, input logic rd,
                            input logic [31:0] wd, input logic [31:0] pad);
    logic        sel;
    logic [31:0] sy, hi, evt, w1c, old_msk;
    logic [2:0]  old_ctrl;
    sel = (a[11:4] == BASE[11:4]);
    // level seen by the edge detector right before this edge
    sy = samp[SS-1];
    hi = samp[SS];
    old_msk  = m_pcmsk;
    old_ctrl = m_ctrl;
    case (old_ctrl[1:0])
      2'd0:    evt = (sy & ~hi) | (~sy & hi);
      2'd1:    evt = sy & ~hi;
      2'd2:    evt = ~sy & hi;
      default: evt = 0;
    endcase
    m_rv = sel && rd;
    m_rd = m_rv ? reg_value(a[3:0]) : 32'h0;
    w1c = 0;
    if (sel && wr) begin
      case (a[3:0])
        4'h0: m_dir = wd & EM;
        4'h1: m_dir = m_dir & ~wd;
        4'h2: m_dir = (m_dir | wd) & EM;
        4'h3: m_dir = (m_dir ^ wd) & EM;
        4'h4: m_out = wd & EM;
        4'h5: m_out = m_out & ~wd;
        4'h6: m_out = (m_out | wd) & EM;
        4'h7: m_out = (m_out ^ wd) & EM;
        4'h9: m_ctrl = wd[2:0];
        4'hA: m_pcmsk = wd & EM;
        4'hB: w1c = wd;
        default: ;
      endcase
    end
    m_pcifr = (m_pcifr & ~w1c) | (evt & old_msk & EM);
    samp.push_front(pad & EM);
    void'(samp.pop_back());
  endtask

  task automatic check_all();
    check("rvalid",   32'(csr_readdatavalid), 32'(m_rv));
    check("rdata",    csr_readdata,           m_rd);
    check("port_out", 32'(port_out),          m_out);
    check("port_oe",  32'(port_oe),           m_dir);
    check("port_in",  32'(port_in),           samp[SS-1]);
    check("irq",      32'(irq),               32'(m_ctrl[2] & (|m_pcifr)));
  endtask

  // One bus cycle: called at a negedge, drives inputs, steps the model at the
  // posedge and compares at the following negedge.
  task automatic cycle(input logic [11:0] a, input logic wr, input logic rd,
                       input logic [31:0] wd, input logic [31:0] pad);
    csr_address   = a;
    csr_write     = wr;
    csr_read      = rd;
    csr_writedata = wd;
    pad_in        = pad[DW-1:0];
    @(posedge clk);
    model_step(a, wr, rd, wd, pad);
    @(negedge clk);
    check_all();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors with hand-derived expectations
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [31:0] pad;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [11:0] a, input logic wr, input logic rd,
                              input logic [31:0] wd, input logic [31:0] pad,
                              input logic ev, input logic [31:0] ed, input logic ei);
    vec_t v;
    v.addr = a; v.wr = wr; v.rd = rd; v.wdata = wd; v.pad = pad;
    v.exp_valid = ev; v.exp_rdata = ed; v.exp_irq = ei;
    return v;
  endfunction

  initial begin
    reset_n = 1'b0;
    csr_address = 0; csr_write = 0; csr_read = 0; csr_writedata = 0; pad_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("reset_oe",    32'(port_oe),  32'h3);
    check("reset_out",   32'(port_out), 32'h0);
    check("reset_valid", 32'(csr_readdatavalid), 32'h0);
    reset_n = 1'b1;

    //              addr   wr rd wdata         pad        v  rdata         irq
    vecs.push_back(mk(12'h040, 0, 1, 32'h0,        32'h2, 1, 32'h0000_0003, 0)); // DIR reset
    vecs.push_back(mk(12'h048, 0, 1, 32'h0,        32'h2, 1, 32'h0000_0000, 0)); // IN, b2b read
    vecs.push_back(mk(12'h044, 1, 0, 32'hFFFF_FFFF, 32'h2, 0, 32'h0,        0)); // OUT
    vecs.push_back(mk(12'h045, 1, 0, 32'h0000_00F0, 32'h2, 0, 32'h0,        0)); // OUTCLR
    vecs.push_back(mk(12'h047, 1, 0, 32'h0000_0101, 32'h2, 0, 32'h0,        0)); // OUTTGL
    vecs.push_back(mk(12'h044, 0, 1, 32'h0,        32'h2, 1, 32'h0380_3E02, 0)); // OUT read
    vecs.push_back(mk(12'h000, 0, 0, 32'h0,        32'h2, 0, 32'h0,        0)); // valid drops
    vecs.push_back(mk(12'h049, 1, 0, 32'h5,        32'h2, 0, 32'h0,        0)); // rise+IRQEN
    vecs.push_back(mk(12'h04A, 1, 0, 32'h3,        32'h2, 0, 32'h0,        0)); // PCMSK
    vecs.push_back(mk(12'h000, 0, 0, 32'h0,        32'h1, 0, 32'h0,        0)); // b0 rise, b1 fall
    vecs.push_back(mk(12'h000, 0, 0, 32'h0,        32'h1, 0, 32'h0,        0));
    vecs.push_back(mk(12'h000, 0, 0, 32'h0,        32'h1, 0, 32'h0,        1)); // flag set
    vecs.push_back(mk(12'h04B, 0, 1, 32'h0,        32'h1, 1, 32'h0000_0001, 1)); // only bit 0
    vecs.push_back(mk(12'h000, 0, 0, 32'h0,        32'h0, 0, 32'h0,        1)); // b0 fall
    vecs.push_back(mk(12'h000, 0, 0, 32'h0,        32'h1, 0, 32'h0,        1)); // b0 rise again
    vecs.push_back(mk(12'h000, 0, 0, 32'h0,        32'h1, 0, 32'h0,        1));
    vecs.push_back(mk(12'h04B, 1, 0, 32'h1,        32'h1, 0, 32'h0,        1)); // W1C vs set
    vecs.push_back(mk(12'h04B, 0, 1, 32'h0,        32'h1, 1, 32'h0000_0001, 1));
    vecs.push_back(mk(12'h04B, 1, 0, 32'h1,        32'h1, 0, 32'h0,        0)); // W1C alone
    vecs.push_back(mk(12'h04B, 0, 1, 32'h0,        32'h1, 1, 32'h0000_0000, 0));
    vecs.push_back(mk(12'h04D, 0, 1, 32'h0,        32'h1, 1, 32'h0000_0000, 0)); // reserved
    vecs.push_back(mk(12'h050, 0, 1, 32'h0,        32'h1, 0, 32'h0,        0)); // outside base
    vecs.push_back(mk(12'h04D, 1, 0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0,        0)); // ignored
    vecs.push_back(mk(12'h04A, 0, 1, 32'h0,        32'h1, 1, 32'h0000_0003, 0));
    vecs.push_back(mk(12'h040, 1, 1, 32'hFF,       32'h1, 1, 32'h0000_0003, 0)); // rd+wr
    vecs.push_back(mk(12'h040, 0, 1, 32'h0,        32'h1, 1, 32'h0000_0073, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata, vecs[i].pad);
      check($sformatf("tbl%0d_valid", i), 32'(csr_readdatavalid), 32'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_rdata", i), csr_readdata,           vecs[i].exp_rdata);
      check($sformatf("tbl%0d_irq",   i), 32'(irq),               32'(vecs[i].exp_irq));
    end

    // Random traffic against the model.
    begin
      logic [31:0] pad;
      logic [11:0] a;
      pad = 32'h1;
      for (int i = 0; i < 600; i++) begin
        pad = pad ^ ($urandom & $urandom & $urandom);
        if ($urandom_range(0, 9) == 0) a = 12'($urandom);
        else                           a = {BASE[11:4], 4'($urandom)};
        cycle(a, 1'($urandom), 1'($urandom), $urandom, pad);
      end
    end

    // Reset pulse between a read strobe and its response.
    csr_address = BASE; csr_read = 1'b1; csr_write = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_valid", 32'(csr_readdatavalid), 32'h0);
    check("async_rst_oe",    32'(port_oe),           32'h3);
    @(posedge clk);
    @(negedge clk);
    check_all();
    check("rst_read_valid", 32'(csr_readdatavalid), 32'h0);
    csr_read = 1'b0;
    reset_n  = 1'b1;
    cycle(12'h000, 0, 0, 0, 0);
    check("post_rst_no_valid", 32'(csr_readdatavalid), 32'h0);

    cycle(BASE | 12'h0, 0, 1, 0, 0);
    check("post_rst_dir",   csr_readdata, 32'h3);
    cycle(BASE | 12'h4, 0, 1, 0, 0);
    check("post_rst_out",   csr_readdata, 32'h0);
    cycle(BASE | 12'h9, 0, 1, 0, 0);
    check("post_rst_ctrl",  csr_readdata, 32'h0);
    cycle(BASE | 12'hA, 0, 1, 0, 0);
    check("post_rst_pcmsk", csr_readdata, 32'h0);
    cycle(BASE | 12'hB, 0, 1, 0, 0);
    check("post_rst_pcifr", csr_readdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
